entropy_i2c_coretest: RTL and testbench
=======================================

Name: entropy_i2c_coretest

Overview:
- Test core for a hardware noise source.
- Samples an asynchronous `noise` pin, turns noise-edge timing jitter into random bytes, and exposes them with status and debug registers through an I2C slave.
- Sits directly under the FPGA top level:
  - SDA is driven only through an external open-drain IOBUF, using `SDA_pd`.
  - `debug` drives board LEDs.

Parameters:
- `I2C_ADDR`, default 7'h0F: 7-bit I2C slave address.
- `FILTER_LEN`, default 3: number of consecutive equal synchronized samples needed before SCL/SDA accept a new level.

Ports:
- `clk` input 1: core clock (25 MHz nominal); all logic is on its rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `noise` input 1: asynchronous entropy source pin.
- `debug` output 8: DEBUG register contents.
- `SCL` input 1: I2C clock from master.
- `SDA` input 1: I2C data as seen on the pad.
- `SDA_pd` output 1: 1 = pull SDA low; 0 = release SDA.

Behaviour:
- Reset values:
  - `SDA_pd`=0, `debug`=0x00.
  - valid=0, overrun=0, shift count=0, edge counter=0, pointer=0x00.
  - I2C FSM in IDLE.
- Input conditioning:
  - `noise`, `SCL` and `SDA` each pass through a 2-flop synchronizer.
  - SCL/SDA then pass the `FILTER_LEN` stability filter.
- Entropy path:
  - A free-running 8-bit counter increments every clk.
  - On each synchronized rising edge of `noise`: shift the counter LSB into an 8-bit shift register (LSB-first) and increment the 8-bit EDGE_CNT (wraps 0xFF→0x00).
  - After 8 bits, in the same cycle:
    - if valid=0, load the DATA register and set valid=1;
    - otherwise discard the byte and set overrun=1.
  - The shift count restarts at 0 in either case.
- I2C bus events:
  - START / repeated START = SDA falls while SCL is high; STOP = SDA rises while SCL is high.
  - Both are recognised in any state and abort the transfer in progress.
  - SDA is sampled on the filtered SCL rising edge.
  - `SDA_pd` changes only after the filtered SCL falling edge.
- FSM states: IDLE, ADDR, ACK_ADDR, WR_BYTE, ACK_WR, RD_BYTE, ACK_RD.
  - ADDR: receive 7 address bits plus R/W, MSB first.
  - Address match → `SDA_pd`=1 for the 9th clock. No match → IDLE, bus untouched until the next START.
- Write transfers:
  - First data byte sets the pointer.
  - Each following byte writes the register at the pointer, then the pointer increments modulo 256.
  - Every write byte is ACKed.
- Read transfers:
  - The register at the pointer is shifted out MSB first via `SDA_pd` = ~bit; SDA is released during the master ACK slot.
  - Master ACK → the pointer increments, except at 0x01, where it stays so DATA can stream.
  - Master NACK → IDLE.
- Register map:
  - 0x00 STATUS (RO): bit0 = valid, bit1 = overrun, bits7:2 = 0. Reading it clears overrun once the byte has been sent.
  - 0x01 DATA (RO): returns the byte when valid=1, else 0x00. valid clears when the byte completes; a byte generated in that same cycle loads normally.
  - 0x02 DEBUG (RW).
  - 0x03 VERSION (RO) = 0x01.
  - 0x04 EDGE_CNT (RO).
  - All other addresses read 0x00. Writes to RO or unmapped addresses are ACKed and ignored.
- Read-byte snapshot: the read byte is latched at the start of the byte, so entropy updates during the shift do not corrupt it.
- Async reset mid-transfer: all state returns to reset values at once and `SDA_pd` releases.

Optional Feature:
- `VON_NEUMANN_EN` defined:
  - Counter-LSB samples are taken in pairs; 01 → bit 0, 10 → bit 1, 00/11 → discarded.
  - Only emitted bits enter the shift register.
  - EDGE_CNT still counts every edge.
- Undefined: every sample enters the shift register directly.

Decomposition:
- Package `entropy_coretest_pkg`:
  - register address constants (0x00–0x04);
  - VERSION constant 0x01;
  - FSM state enumeration typedef;
  - STATUS bit index constants.
- One sub-module, `i2c_reg_slave`:
  - contains the filters, START/STOP detection and FSM;
  - exposes `reg_addr`, `reg_wdata`, `reg_we`, `reg_rdata`, `reg_rd_done` to the parent, which holds the registers and the entropy path.

Test Plan:
- Reset → `debug`=0x00, `SDA_pd`=0; read 0x03 → 0x01; read 0x00 → 0x00.
- Write {0x1E, 0x02, 0xA5} then read 0x02 → `debug`=0xA5 and read data 0xA5; a write to address 0x1C (7'h0E) gets no ACK and `SDA_pd` stays 0.
- Drive 8 `noise` rising edges with controlled phase:
  - STATUS → 0x01;
  - DATA matches the expected counter-LSB byte;
  - a second DATA read returns 0x00 and STATUS → 0x00.
- Drive 16 edges without reading → STATUS 0x03; read STATUS again → 0x01.
- Drive 300 `noise` edges → EDGE_CNT reads 0x2C.
- Assert `reset_n` mid read-byte → `SDA_pd`=0 at once; the next transfer with START works normally; with `VON_NEUMANN_EN`, sample pattern 0,0,0,1,1,0,... yields bits 0,1.

Source files
------------

// File: rtl/entropy_coretest_pkg.sv
// Shared register map, STATUS bit positions and I2C slave state encoding for the entropy test core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package entropy_coretest_pkg;

    localparam logic [7:0] REG_STATUS   = 8'h00;
    localparam logic [7:0] REG_DATA     = 8'h01;
    localparam logic [7:0] REG_DEBUG    = 8'h02;
    localparam logic [7:0] REG_VERSION  = 8'h03;
    localparam logic [7:0] REG_EDGE_CNT = 8'h04;

    localparam logic [7:0] VERSION = 8'h01;

    localparam int STATUS_VALID_BIT   = 0;
    localparam int STATUS_OVERRUN_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_WR_BYTE,
        ST_ACK_WR,
        ST_RD_BYTE,
        ST_ACK_RD
    } i2c_state_t;

endpackage

// File: rtl/i2c_reg_slave.sv
// I2C register slave: SCL/SDA sync + stability filter, START/STOP detect, byte FSM, register pointer.
// Latency: bus edges seen 2+FILTER_LEN clk after the pad; SDA_pd updates one clk after the filtered SCL fall.
// Backpressure: none; the master owns SCL, no clock stretching.
module i2c_reg_slave
    import entropy_coretest_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR   = 7'h0F,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_pd,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       reg_rd_done
);

    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-1:0] scl_hist, sda_hist;
    logic                  scl_f, sda_f, scl_q, sda_q;
    logic                  scl_rise, scl_fall, start_det, stop_det;

    i2c_state_t state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg, rd_sh, ptr;
    logic       rw, first_byte, got_ack;

    assign reg_addr = ptr;

    // Idle bus is high, so the conditioning chain resets to 1 to avoid a false START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_hist <= (scl_hist << 1) | FILTER_LEN'(scl_sync[1]);
            sda_hist <= (sda_hist << 1) | FILTER_LEN'(sda_sync[1]);
            if (&scl_hist)       scl_f <= 1'b1;
            else if (~|scl_hist) scl_f <= 1'b0;
            if (&sda_hist)       sda_f <= 1'b1;
            else if (~|sda_hist) sda_f <= 1'b0;
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sda_pd      <= 1'b0;
            bit_cnt     <= 4'd0;
            shreg       <= 8'h00;
            rd_sh       <= 8'h00;
            ptr         <= 8'h00;
            rw          <= 1'b0;
            first_byte  <= 1'b0;
            got_ack     <= 1'b0;
            reg_we      <= 1'b0;
            reg_wdata   <= 8'h00;
            reg_rd_done <= 1'b0;
        end else begin
            reg_we      <= 1'b0;
            reg_rd_done <= 1'b0;
            // Pointer advances the cycle after the write strobe so the strobe sees the old address.
            if (reg_we) ptr <= ptr + 8'd1;

            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_pd  <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_pd <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_ADDR, ST_WR_BYTE: begin
                        shreg   <= {shreg[6:0], sda_f};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    ST_RD_BYTE: bit_cnt <= bit_cnt + 4'd1;
                    // Advance here so reg_rdata is already valid for the snapshot on the next fall.
                    ST_ACK_RD: begin
                        got_ack <= ~sda_f;
                        if (!sda_f && ptr != REG_DATA) ptr <= ptr + 8'd1;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ST_ADDR: begin
                        if (bit_cnt == 4'd8) begin
                            if (shreg[7:1] == I2C_ADDR) begin
                                state  <= ST_ACK_ADDR;
                                sda_pd <= 1'b1;
                                rw     <= shreg[0];
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_ACK_ADDR: begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                            state  <= ST_RD_BYTE;
                            rd_sh  <= reg_rdata;
                            sda_pd <= ~reg_rdata[7];
                        end else begin
                            state      <= ST_WR_BYTE;
                            sda_pd     <= 1'b0;
                            first_byte <= 1'b1;
                        end
                    end
                    ST_WR_BYTE: begin
                        if (bit_cnt == 4'd8) begin
                            state  <= ST_ACK_WR;
                            sda_pd <= 1'b1;
                            if (first_byte) begin
                                ptr <= shreg;
                            end else begin
                                reg_we    <= 1'b1;
                                reg_wdata <= shreg;
                            end
                        end
                    end
                    ST_ACK_WR: begin
                        state      <= ST_WR_BYTE;
                        sda_pd     <= 1'b0;
                        bit_cnt    <= 4'd0;
                        first_byte <= 1'b0;
                    end
                    ST_RD_BYTE: begin
                        if (bit_cnt == 4'd8) begin
                            state       <= ST_ACK_RD;
                            sda_pd      <= 1'b0;
                            reg_rd_done <= 1'b1;
                        end else begin
                            sda_pd <= ~rd_sh[3'd7 - bit_cnt[2:0]];
                        end
                    end
                    ST_ACK_RD: begin
                        bit_cnt <= 4'd0;
                        if (got_ack) begin
                            state  <= ST_RD_BYTE;
                            rd_sh  <= reg_rdata;
                            sda_pd <= ~reg_rdata[7];
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/entropy_i2c_coretest.sv
// Noise-jitter entropy core with I2C register access; `define VON_NEUMANN_EN to debias sample pairs.
// Latency: noise edge sampled 3 clk after the pin rises; register reads snapshot at the start of each byte.
// Backpressure: one-byte DATA buffer; bytes completed while it is full are dropped and flag overrun.
module entropy_i2c_coretest
    import entropy_coretest_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR   = 7'h0F,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       noise,
    output logic [7:0] debug,
    input  logic       SCL,
    input  logic       SDA,
    output logic       SDA_pd
);

    logic [1:0] noise_sync;
    logic       noise_q, noise_rise;
    logic [7:0] free_cnt, edge_cnt, ent_sh, data_reg;
    logic [2:0] sh_cnt;
    logic       valid, overrun;
    logic       bit_vld, bit_val, byte_done, valid_eff;
    logic [7:0] new_byte;

    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_rd_done;
    logic       data_rd_done, status_rd_done;

    i2c_reg_slave #(
        .I2C_ADDR   (I2C_ADDR),
        .FILTER_LEN (FILTER_LEN)
    ) u_slave (
        .clk         (clk),
        .reset_n     (reset_n),
        .scl         (SCL),
        .sda         (SDA),
        .sda_pd      (SDA_pd),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_rdata   (reg_rdata),
        .reg_rd_done (reg_rd_done)
    );

    assign noise_rise = noise_sync[1] & ~noise_q;

`ifdef VON_NEUMANN_EN
    logic pair_have, pair_first;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_have  <= 1'b0;
            pair_first <= 1'b0;
        end else if (noise_rise) begin
            pair_have  <= ~pair_have;
            pair_first <= free_cnt[0];
        end
    end

    // Unequal pair emits its first sample; equal pairs carry bias and are dropped.
    always_comb begin
        bit_vld = noise_rise & pair_have & (pair_first != free_cnt[0]);
        bit_val = pair_first;
    end
`else
    always_comb begin
        bit_vld = noise_rise;
        bit_val = free_cnt[0];
    end
`endif

    assign new_byte       = {bit_val, ent_sh[7:1]};
    assign byte_done      = bit_vld && (sh_cnt == 3'd7);
    assign data_rd_done   = reg_rd_done && (reg_addr == REG_DATA);
    assign status_rd_done = reg_rd_done && (reg_addr == REG_STATUS);
    // A DATA read finishing this cycle frees the buffer for a byte finishing in the same cycle.
    assign valid_eff      = valid & ~data_rd_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            noise_sync <= 2'b00;
            noise_q    <= 1'b0;
            free_cnt   <= 8'h00;
            edge_cnt   <= 8'h00;
            ent_sh     <= 8'h00;
            sh_cnt     <= 3'd0;
            data_reg   <= 8'h00;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            debug      <= 8'h00;
        end else begin
            noise_sync <= {noise_sync[0], noise};
            noise_q    <= noise_sync[1];
            free_cnt   <= free_cnt + 8'd1;
            if (noise_rise) edge_cnt <= edge_cnt + 8'd1;
            if (bit_vld) begin
                ent_sh <= new_byte;
                sh_cnt <= sh_cnt + 3'd1;
            end
            if (status_rd_done) overrun <= 1'b0;
            if (data_rd_done)   valid   <= 1'b0;
            if (byte_done) begin
                if (!valid_eff) begin
                    data_reg <= new_byte;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (reg_we && reg_addr == REG_DEBUG) debug <= reg_wdata;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            REG_STATUS: begin
                reg_rdata[STATUS_VALID_BIT]   = valid;
                reg_rdata[STATUS_OVERRUN_BIT] = overrun;
            end
            REG_DATA:     reg_rdata = valid ? data_reg : 8'h00;
            REG_DEBUG:    reg_rdata = debug;
            REG_VERSION:  reg_rdata = VERSION;
            REG_EDGE_CNT: reg_rdata = edge_cnt;
            default:      reg_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_entropy_i2c_coretest.sv
// Bench for entropy_i2c_coretest: bit-banged I2C master, table of register accesses, entropy corner sequences.
`timescale 1ns/1ps
module tb_entropy_i2c_coretest;

    localparam int Q = 80;  // quarter I2C bit period

    logic       clk = 1'b0;
    logic       reset_n;
    logic       noise;
    logic [7:0] debug;
    logic       scl, sda_m;
    logic       sda_line;
    logic       SDA_pd;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int pd_cnt;

    assign sda_line = sda_m & ~SDA_pd;

    entropy_i2c_coretest dut (
        .clk     (clk),
        .reset_n (reset_n),
        .noise   (noise),
        .debug   (debug),
        .SCL     (scl),
        .SDA     (sda_line),
        .SDA_pd  (SDA_pd)
    );

    always #5 clk = ~clk;

    // Reference clock count since reset release: the free-running counter value by definition.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(posedge clk) if (SDA_pd === 1'b1) pd_cnt = pd_cnt + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic i2c_start;
        #Q; sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0;
    endtask

    task automatic i2c_stop;
        #Q; sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            #Q; sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
        end
        #Q; sda_m = 1'b1; #Q; scl = 1'b1; #Q; ack = ~sda_line; #Q; scl = 1'b0;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            #Q; sda_m = 1'b1; #Q; scl = 1'b1; #Q; b[i] = sda_line; #Q; scl = 1'b0;
        end
        #Q; sda_m = ~ack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
    endtask

    task automatic set_ptr(input logic [7:0] ptr);
        logic a;
        i2c_start;
        wr_byte(8'h1E, a); chk("addr_w_ack", 8'(a), 8'h01);
        wr_byte(ptr, a);   chk("ptr_ack", 8'(a), 8'h01);
    endtask

    task automatic rd_reg(input logic [7:0] ptr, input int n, output logic [7:0] d0, output logic [7:0] d1);
        logic a;
        set_ptr(ptr);
        i2c_start;
        wr_byte(8'h1F, a); chk("addr_r_ack", 8'(a), 8'h01);
        d1 = 8'h00;
        if (n == 2) begin
            rd_byte(1'b1, d0);
            rd_byte(1'b0, d1);
        end else begin
            rd_byte(1'b0, d0);
        end
        i2c_stop;
    endtask

    task automatic wr_reg(input logic [7:0] ptr, input logic [7:0] d);
        logic a;
        set_ptr(ptr);
        wr_byte(d, a); chk("data_ack", 8'(a), 8'h01);
        i2c_stop;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; scl = 1'b1; sda_m = 1'b1; noise = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    // Raise noise when the reference count parity equals b; the core then shifts in b.
    task automatic noise_edge(input logic b);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (cyc[0] == b) break;
        end
        noise = 1'b1;
        repeat (4) @(posedge clk);
        #1 noise = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic ent_bit(input logic b);
`ifdef VON_NEUMANN_EN
        noise_edge(b);
        noise_edge(~b);
`else
        noise_edge(b);
`endif
    endtask

    task automatic ent_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) ent_bit(v[i]);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] ptr;
        logic [7:0] val;
        logic [7:0] dbg;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] d0, d1;
        logic       a;
        int         pd_before;

        pd_cnt  = 0;
        reset_n = 1'b0; scl = 1'b1; sda_m = 1'b1; noise = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_debug", debug, 8'h00);
        chk("rst_sda_pd", 8'(SDA_pd), 8'h00);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        vecs[0]  = '{1'b0, 8'h03, 8'h01, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 8'h02, 8'hA5, 8'hA5};
        vecs[3]  = '{1'b0, 8'h02, 8'hA5, 8'hA5};
        vecs[4]  = '{1'b0, 8'h04, 8'h00, 8'hA5};
        vecs[5]  = '{1'b0, 8'h05, 8'h00, 8'hA5};
        vecs[6]  = '{1'b1, 8'h03, 8'h55, 8'hA5};
        vecs[7]  = '{1'b0, 8'h03, 8'h01, 8'hA5};
        vecs[8]  = '{1'b1, 8'h7F, 8'h99, 8'hA5};
        vecs[9]  = '{1'b0, 8'h7F, 8'h00, 8'hA5};
        vecs[10] = '{1'b1, 8'h02, 8'h3C, 8'h3C};
        vecs[11] = '{1'b0, 8'h01, 8'h00, 8'h3C};

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                wr_reg(vecs[i].ptr, vecs[i].val);
            end else begin
                rd_reg(vecs[i].ptr, 1, d0, d1);
                chk($sformatf("vec%0d_rdata", i), d0, vecs[i].val);
            end
            chk($sformatf("vec%0d_debug", i), debug, vecs[i].dbg);
        end

        // Wrong slave address: no ACK and SDA never pulled.
        pd_before = pd_cnt;
        i2c_start;
        wr_byte(8'h1C, a);
        chk("wrong_addr_ack", 8'(a), 8'h00);
        i2c_stop;
        chk("wrong_addr_pd_cycles", 8'(pd_cnt - pd_before), 8'h00);

        // Burst write: DEBUG then read-only VERSION; burst read shows auto-increment.
        set_ptr(8'h02);
        wr_byte(8'h11, a); chk("burst_ack0", 8'(a), 8'h01);
        wr_byte(8'h77, a); chk("burst_ack1", 8'(a), 8'h01);
        i2c_stop;
        chk("burst_debug", debug, 8'h11);
        rd_reg(8'h02, 2, d0, d1);
        chk("burst_rd0", d0, 8'h11);
        chk("burst_rd1", d1, 8'h01);

        // One entropy byte, streamed DATA read, then buffer empty.
`ifdef VON_NEUMANN_EN
        noise_edge(1'b1);
        noise_edge(1'b1);
`endif
        ent_byte(8'hB4);
        rd_reg(8'h00, 1, d0, d1);
        chk("ent_status_valid", d0, 8'h01);
        rd_reg(8'h01, 2, d0, d1);
        chk("ent_data", d0, 8'hB4);
        chk("ent_data_again", d1, 8'h00);
        rd_reg(8'h00, 1, d0, d1);
        chk("ent_status_empty", d0, 8'h00);

        // Two bytes without reading: overrun, cleared by the STATUS read.
        ent_byte(8'h5A);
        ent_byte(8'hC3);
        rd_reg(8'h00, 1, d0, d1);
        chk("ovr_status", d0, 8'h03);
        rd_reg(8'h00, 1, d0, d1);
        chk("ovr_status_cleared", d0, 8'h01);
        rd_reg(8'h01, 1, d0, d1);
        chk("ovr_data_first_kept", d0, 8'h5A);

        // Async reset in the middle of a read byte.
        set_ptr(8'h03);
        i2c_start;
        wr_byte(8'h1F, a); chk("mid_addr_r_ack", 8'(a), 8'h01);
        #Q; sda_m = 1'b1; #Q; scl = 1'b1; #(Q/2);
        chk("mid_rd_bit7_pd", 8'(SDA_pd), 8'h01);
        reset_n = 1'b0;
        #1;
        chk("arst_sda_pd", 8'(SDA_pd), 8'h00);
        chk("arst_debug", debug, 8'h00);
        #Q;
        reset_n = 1'b1; scl = 1'b1; sda_m = 1'b1;
        repeat (10) @(posedge clk);
        i2c_start;
        wr_byte(8'h1F, a); chk("post_rst_ack", 8'(a), 8'h01);
        rd_byte(1'b0, d0);
        i2c_stop;
        chk("post_rst_ptr_status", d0, 8'h00);
        rd_reg(8'h03, 1, d0, d1);
        chk("post_rst_version", d0, 8'h01);

        // EDGE_CNT wraps: 300 edges leave 300 mod 256.
        do_reset;
        for (int i = 0; i < 300; i++) noise_edge(i[0]);
        rd_reg(8'h04, 1, d0, d1);
        chk("edge_cnt_wrap", d0, 8'h2C);
        rd_reg(8'h00, 1, d0, d1);
        chk("edge_status", d0, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
